// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous-read ROM between fetch and load.
// One request in flight at a time; data returns two cycles after grant with a valid strobe.
module rom_arbiter #(
    parameter int unsigned N    = 32,
    parameter int unsigned SIZE = 1024,
    localparam int unsigned AW  = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic          if_err,
    output logic [N-1:0]  if_rdata,
    input  logic          ls_req,
    input  logic [AW-1:0] ls_addr,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic          ls_err,
    output logic [N-1:0]  ls_rdata,
    output logic [AW-1:0] rom_addr,
    input  logic [N-1:0]  rom_data
);
    localparam int unsigned LAST_OK = SIZE - 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_ls;
    logic          err_q;
    logic          last_ls;
    logic          accept;
    logic          pick_ls;
    logic [AW-1:0] sel_addr;

    // Arbitration and next state: accept possible in IDLE and DATA, never during ISSUE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        pick_ls   = 1'b0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if (rstn && (state != ISSUE) && (if_req || ls_req)) begin
            accept  = 1'b1;
            pick_ls = ls_req && (!if_req || !last_ls);
            if_gnt  = !pick_ls;
            ls_gnt  = pick_ls;
        end
        sel_addr = pick_ls ? ls_addr : if_addr;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = DATA;
            DATA:    state_nxt = accept ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Transaction context captured on accept and held through ISSUE and DATA.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rom_addr <= '0;
            owner_ls <= 1'b0;
            err_q    <= 1'b0;
            last_ls  <= 1'b1;
        end else if (accept) begin
            rom_addr <= sel_addr;
            owner_ls <= pick_ls;
            err_q    <= (sel_addr > AW'(LAST_OK));
            last_ls  <= pick_ls;
        end
    end

    // Response decode: only the owner sees rvalid; out-of-range reads return zero.
    always_comb begin
        if_rvalid = (state == DATA) && !owner_ls;
        ls_rvalid = (state == DATA) && owner_ls;
        if_err    = if_rvalid && err_q;
        ls_err    = ls_rvalid && err_q;
        if_rdata  = (if_rvalid && !err_q) ? rom_data : '0;
        ls_rdata  = (ls_rvalid && !err_q) ? rom_data : '0;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed vector table, hand sequences for
// contention and reset, and a randomized run against a transaction-level model.
module tb_rom_arbiter;
    localparam int unsigned N    = 32;
    localparam int unsigned SIZE = 1024;
    localparam int unsigned AW   = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid, if_err;
    logic [N-1:0]  if_rdata;
    logic          ls_req = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic          ls_gnt, ls_rvalid, ls_err;
    logic [N-1:0]  ls_rdata;
    logic [AW-1:0] rom_addr;
    logic [N-1:0]  rom_data = '0;

    int total  = 0;
    int passed = 0;

    rom_arbiter #(.N(N), .SIZE(SIZE)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_err(if_err), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // ROM contents: memory[i] = i[7:0], little-endian 32-bit words.
    function automatic logic [31:0] rom_word(input int a);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            if (a + k < int'(SIZE)) w[8*k +: 8] = 8'((a + k) % 256);
        return w;
    endfunction

    always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(SIZE - 8, SIZE - 1));
        return AW'($urandom_range(0, SIZE - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc_start();
        rstn   = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    typedef struct {
        bit          is_ls;
        int          addr;
        bit          err;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[8];

    // Single isolated transaction: grant in cycle 0, data in cycle 2.
    task automatic do_txn(input vec_t v);
        cyc_start();
        if (v.is_ls) begin ls_req = 1'b1; ls_addr = AW'(v.addr); end
        else         begin if_req = 1'b1; if_addr = AW'(v.addr); end
        @(negedge clk);
        chk("txn_gnt", 32'({if_gnt, ls_gnt}), v.is_ls ? 32'd1 : 32'd2);
        cyc_start();
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        chk("txn_issue_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
        chk("txn_rom_addr", 32'(rom_addr), 32'(v.addr));
        cyc_start();
        @(negedge clk);
        chk("txn_rvalid", 32'({if_rvalid, ls_rvalid}), v.is_ls ? 32'd1 : 32'd2);
        chk("txn_err", 32'({if_err, ls_err}), v.err ? (v.is_ls ? 32'd1 : 32'd2) : 32'd0);
        chk("txn_rdata", v.is_ls ? ls_rdata : if_rdata, v.data);
    endtask

    typedef struct {
        int due;
        bit is_ls;
        int addr;
    } pend_t;

    initial begin
        pend_t       q[$];
        pend_t       t;
        bit          acc_prev, last_m, exp_if, exp_ls, ev_if, ev_ls, ee;
        bit          if_got, ls_got;
        logic [31:0] ed;

        vecs[0] = '{1'b0, 4,    1'b0, 32'h07060504};
        vecs[1] = '{1'b0, 5,    1'b0, 32'h08070605};
        vecs[2] = '{1'b1, 1021, 1'b1, 32'h00000000};
        vecs[3] = '{1'b1, 1020, 1'b0, 32'hFFFEFDFC};
        vecs[4] = '{1'b0, 0,    1'b0, 32'h03020100};
        vecs[5] = '{1'b1, 8,    1'b0, 32'h0B0A0908};
        vecs[6] = '{1'b0, 1023, 1'b1, 32'h00000000};
        vecs[7] = '{1'b1, 3,    1'b0, 32'h06050403};

        // Reset state, with both requests high to show gnt is held off.
        if_req = 1'b1;
        ls_req = 1'b1;
        @(negedge clk);
        chk("rst_ctl", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err}), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
        do_reset();

        foreach (vecs[i]) do_txn(vecs[i]);

        // Simultaneous requests from reset: fetch first, load two cycles later.
        do_reset();
        cyc_start();
        if_req = 1'b1; if_addr = AW'(0);
        ls_req = 1'b1; ls_addr = AW'(8);
        @(negedge clk);
        chk("sim_gnt0", 32'({if_gnt, ls_gnt}), 32'd2);
        cyc_start();
        if_req = 1'b0;
        @(negedge clk);
        chk("sim_gnt1", 32'({if_gnt, ls_gnt}), 32'd0);
        cyc_start();
        @(negedge clk);
        chk("sim_gnt2", 32'({if_gnt, ls_gnt}), 32'd1);
        chk("sim_if_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd2);
        chk("sim_if_rdata", if_rdata, 32'h03020100);
        cyc_start();
        ls_req = 1'b0;
        cyc_start();
        @(negedge clk);
        chk("sim_ls_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd1);
        chk("sim_ls_rdata", ls_rdata, 32'h0B0A0908);

        // Sustained contention: 8 alternating grants, one every two cycles.
        do_reset();
        cyc_start();
        if_req = 1'b1; if_addr = AW'(16);
        ls_req = 1'b1; ls_addr = AW'(32);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("alt_gnt", 32'({if_gnt, ls_gnt}),
                (k % 2 == 1) ? 32'd0 : (((k / 2) % 2 == 0) ? 32'd2 : 32'd1));
            if (k >= 2)
                chk("alt_rvalid", 32'({if_rvalid, ls_rvalid}),
                    (k % 2 == 1) ? 32'd0 : ((((k - 2) / 2) % 2 == 0) ? 32'd2 : 32'd1));
            if (k < 15) cyc_start();
        end
        cyc_start();
        if_req = 1'b0;
        ls_req = 1'b0;
        cyc_start();

        // Reset asserted during the ISSUE cycle of a load.
        do_reset();
        cyc_start();
        ls_req = 1'b1; ls_addr = AW'(12);
        @(negedge clk);
        chk("mid_ls_gnt", 32'({if_gnt, ls_gnt}), 32'd1);
        cyc_start();
        ls_req = 1'b0;
        #1 rstn = 1'b0;
        if_req = 1'b1; if_addr = AW'(16);
        ls_req = 1'b1; ls_addr = AW'(20);
        @(negedge clk);
        chk("mid_rst_ctl", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err}), 32'd0);
        chk("mid_rst_rdata", if_rdata | ls_rdata, 32'd0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        repeat (2) begin
            cyc_start();
            @(negedge clk);
            chk("mid_rst_no_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
        end
        cyc_start();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", 32'({if_gnt, ls_gnt}), 32'd2);
        cyc_start();
        if_req = 1'b0;
        @(negedge clk);
        chk("post_rst_issue", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid}), 32'd0);
        cyc_start();
        @(negedge clk);
        chk("post_rst_data", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid}), 32'b0110);
        chk("post_rst_if_rdata", if_rdata, rom_word(16));
        cyc_start();
        ls_req = 1'b0;
        cyc_start();
        @(negedge clk);
        chk("post_rst_ls_rdata", ls_rdata, rom_word(20));

        // Randomized run against a transaction-level reference model.
        do_reset();
        acc_prev = 1'b0;
        last_m   = 1'b1;
        if_got   = 1'b0;
        ls_got   = 1'b0;
        q.delete();
        for (int c = 0; c < 800; c++) begin
            cyc_start();
            if (!if_req || if_got) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = rand_addr();
            end
            if (!ls_req || ls_got) begin
                ls_req  = ($urandom_range(0, 2) != 0);
                ls_addr = rand_addr();
            end
            @(negedge clk);
            ev_if = 1'b0; ev_ls = 1'b0; ee = 1'b0; ed = '0;
            if (q.size() > 0 && q[0].due == c) begin
                t     = q.pop_front();
                ev_ls = t.is_ls;
                ev_if = !t.is_ls;
                ee    = (t.addr > int'(SIZE) - 4);
                ed    = ee ? 32'd0 : rom_word(t.addr);
            end
            exp_if = 1'b0;
            exp_ls = 1'b0;
            if (!acc_prev && (if_req || ls_req)) begin
                exp_ls = (if_req && ls_req) ? !last_m : ls_req;
                exp_if = !exp_ls;
                last_m = exp_ls;
                q.push_back('{c + 2, exp_ls, exp_ls ? int'(ls_addr) : int'(if_addr)});
            end
            acc_prev = exp_if || exp_ls;
            chk("rnd_ctl", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err}),
                32'({exp_if, exp_ls, ev_if, ev_ls, ev_if && ee, ev_ls && ee}));
            if (ev_if) chk("rnd_if_rdata", if_rdata, ed);
            if (ev_ls) chk("rnd_ls_rdata", ls_rdata, ed);
            if_got = if_gnt;
            ls_got = ls_gnt;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
